// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the 16-bit TSC datapath: IF/ID/EX/MEM/WB sequencing,
// variable-latency memory handshake with timeout, sticky HALT, retired-instruction counter.
module mc_control_fsm #(
  parameter int OPCODE_W = 4,
  parameter int FUNCT_W  = 6,
  parameter int ALUOP_W  = 4,
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [FUNCT_W-1:0]  funct_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                pc_write_cond_o,
  output logic                i_or_d_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic                reg_write_o,
  output logic [1:0]          mem_to_reg_o,
  output logic [1:0]          reg_dst_o,
  output logic [1:0]          alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [1:0]          pc_source_o,
  output logic [ALUOP_W-1:0]  alu_op_o,
  output logic                wwd_out_o,
  output logic                is_halted_o,
  output logic                mem_err_o,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    retired_o
);

  typedef enum logic [2:0] {
    S_IF    = 3'b000,
    S_ID    = 3'b001,
    S_EX    = 3'b010,
    S_WB    = 3'b011,
    S_HALT  = 3'b100,
    S_MEM   = 3'b110,
    S_RESET = 3'b111
  } state_e;

  localparam logic [OPCODE_W-1:0] OPC_BNE = OPCODE_W'(4'd0);
  localparam logic [OPCODE_W-1:0] OPC_BEQ = OPCODE_W'(4'd1);
  localparam logic [OPCODE_W-1:0] OPC_BGZ = OPCODE_W'(4'd2);
  localparam logic [OPCODE_W-1:0] OPC_BLZ = OPCODE_W'(4'd3);
  localparam logic [OPCODE_W-1:0] OPC_ADI = OPCODE_W'(4'd4);
  localparam logic [OPCODE_W-1:0] OPC_ORI = OPCODE_W'(4'd5);
  localparam logic [OPCODE_W-1:0] OPC_LHI = OPCODE_W'(4'd6);
  localparam logic [OPCODE_W-1:0] OPC_LWD = OPCODE_W'(4'd7);
  localparam logic [OPCODE_W-1:0] OPC_SWD = OPCODE_W'(4'd8);
  localparam logic [OPCODE_W-1:0] OPC_JMP = OPCODE_W'(4'd9);
  localparam logic [OPCODE_W-1:0] OPC_JAL = OPCODE_W'(4'd10);
  localparam logic [OPCODE_W-1:0] OPC_R   = OPCODE_W'(4'd15);

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'd0);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'd1);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'd2);
  localparam logic [FUNCT_W-1:0] FN_ORR = FUNCT_W'(6'd3);
  localparam logic [FUNCT_W-1:0] FN_NOT = FUNCT_W'(6'd4);
  localparam logic [FUNCT_W-1:0] FN_TCP = FUNCT_W'(6'd5);
  localparam logic [FUNCT_W-1:0] FN_SHL = FUNCT_W'(6'd6);
  localparam logic [FUNCT_W-1:0] FN_SHR = FUNCT_W'(6'd7);
  localparam logic [FUNCT_W-1:0] FN_JPR = FUNCT_W'(6'd25);
  localparam logic [FUNCT_W-1:0] FN_JRL = FUNCT_W'(6'd26);
  localparam logic [FUNCT_W-1:0] FN_WWD = FUNCT_W'(6'd28);
  localparam logic [FUNCT_W-1:0] FN_HLT = FUNCT_W'(6'd29);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(4'd0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(4'd1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(4'd2);
  localparam logic [ALUOP_W-1:0] ALU_ORR = ALUOP_W'(4'd3);
  localparam logic [ALUOP_W-1:0] ALU_NOT = ALUOP_W'(4'd4);
  localparam logic [ALUOP_W-1:0] ALU_TCP = ALUOP_W'(4'd5);
  localparam logic [ALUOP_W-1:0] ALU_LLS = ALUOP_W'(4'd6);
  localparam logic [ALUOP_W-1:0] ALU_ARS = ALUOP_W'(4'd7);
  localparam logic [ALUOP_W-1:0] ALU_BNE = ALUOP_W'(4'd8);
  localparam logic [ALUOP_W-1:0] ALU_BEQ = ALUOP_W'(4'd9);
  localparam logic [ALUOP_W-1:0] ALU_BGZ = ALUOP_W'(4'd10);
  localparam logic [ALUOP_W-1:0] ALU_BLZ = ALUOP_W'(4'd11);
  localparam logic [ALUOP_W-1:0] ALU_ID  = ALUOP_W'(4'd12);

  state_e             state_q, state_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               mem_err_q, mem_err_d;
  logic               timeout_s;
  logic               retire_s;
  logic               wait_hit_s;

  assign wait_hit_s = (wait_cnt_q == 8'(WAIT_MAX));

  // Next-state and Moore strobe decode
  always_comb begin
    state_d         = state_q;
    timeout_s       = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    wwd_out_o       = 1'b0;
    mem_to_reg_o    = 2'b00;
    reg_dst_o       = 2'b00;
    alu_src_a_o     = 2'b00;
    alu_src_b_o     = 2'b00;
    pc_source_o     = 2'b00;
    alu_op_o        = ALU_ADD;
    case (state_q)
      S_RESET: state_d = S_IF;
      S_IF: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i) begin
          state_d = S_ID;
        end else if (wait_hit_s) begin
          state_d   = S_HALT;
          timeout_s = 1'b1;
        end else begin
          state_d = S_IF;
        end
      end
      S_ID: begin
        alu_src_b_o = 2'b10;
        case (opcode_i)
          OPC_JMP: begin
            pc_write_o  = 1'b1;
            pc_source_o = 2'b01;
            state_d     = S_IF;
          end
          OPC_JAL: begin
            pc_write_o   = 1'b1;
            pc_source_o  = 2'b01;
            reg_write_o  = 1'b1;
            reg_dst_o    = 2'b10;
            mem_to_reg_o = 2'b10;
            state_d      = S_IF;
          end
          OPC_R: begin
            // funct 01xxxx are the control-type R instructions finished in ID
            if (funct_i[FUNCT_W-1 -: 2] == 2'b01) begin
              state_d = S_IF;
              case (funct_i)
                FN_JPR: begin
                  pc_write_o  = 1'b1;
                  pc_source_o = 2'b11;
                end
                FN_JRL: begin
                  pc_write_o   = 1'b1;
                  pc_source_o  = 2'b11;
                  reg_write_o  = 1'b1;
                  reg_dst_o    = 2'b10;
                  mem_to_reg_o = 2'b10;
                end
                FN_WWD:  wwd_out_o = 1'b1;
                FN_HLT:  state_d = S_HALT;
                default: state_d = S_IF;
              endcase
            end else begin
              state_d = S_EX;
            end
          end
          OPC_BNE, OPC_BEQ, OPC_BGZ, OPC_BLZ,
          OPC_ADI, OPC_ORI, OPC_LHI, OPC_LWD, OPC_SWD: state_d = S_EX;
          default: state_d = S_IF;
        endcase
      end
      S_EX: begin
        case (opcode_i)
          OPC_R: begin
            alu_src_a_o = 2'b01;
            state_d     = S_WB;
            case (funct_i)
              FN_ADD: alu_op_o = ALU_ADD;
              FN_SUB: alu_op_o = ALU_SUB;
              FN_AND: alu_op_o = ALU_AND;
              FN_ORR: alu_op_o = ALU_ORR;
              FN_NOT: alu_op_o = ALU_NOT;
              FN_TCP: alu_op_o = ALU_TCP;
              FN_SHL: alu_op_o = ALU_LLS;
              FN_SHR: alu_op_o = ALU_ARS;
              default: state_d = S_IF;
            endcase
          end
          OPC_ADI, OPC_ORI, OPC_LWD, OPC_SWD: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
            alu_op_o    = (opcode_i == OPC_ORI) ? ALU_ORR : ALU_ADD;
            state_d     = ((opcode_i == OPC_LWD) || (opcode_i == OPC_SWD)) ? S_MEM : S_WB;
          end
          OPC_LHI: begin
            alu_src_a_o = 2'b10;
            alu_op_o    = ALU_ID;
            state_d     = S_WB;
          end
          OPC_BNE, OPC_BEQ, OPC_BGZ, OPC_BLZ: begin
            alu_src_a_o     = 2'b01;
            pc_source_o     = 2'b10;
            pc_write_cond_o = 1'b1;
            state_d         = S_IF;
            case (opcode_i)
              OPC_BNE: alu_op_o = ALU_BNE;
              OPC_BEQ: alu_op_o = ALU_BEQ;
              OPC_BGZ: alu_op_o = ALU_BGZ;
              default: alu_op_o = ALU_BLZ;
            endcase
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        i_or_d_o = 1'b1;
        if (opcode_i == OPC_LWD) begin
          mem_read_o = 1'b1;
        end else if (opcode_i == OPC_SWD) begin
          mem_write_o = 1'b1;
        end else begin
          mem_read_o = 1'b0;
        end
        if (mem_ready_i) begin
          state_d = (opcode_i == OPC_LWD) ? S_WB : S_IF;
        end else if (wait_hit_s) begin
          state_d   = S_HALT;
          timeout_s = 1'b1;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (opcode_i == OPC_R) ? 2'b01 : 2'b00;
        mem_to_reg_o = (opcode_i == OPC_LWD) ? 2'b01 : 2'b00;
        state_d      = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // Wait counter, retire counter and sticky error next values
  always_comb begin
    wait_cnt_d = 8'd0;
    retire_s   = 1'b0;
    if (((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready_i && (state_d == state_q)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = 8'd0;
    end
    if ((state_d == S_IF) &&
        ((state_q == S_ID) || (state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB))) begin
      retire_s = 1'b1;
    end else if ((state_q == S_ID) && (state_d == S_HALT)) begin
      retire_s = 1'b1;
    end else begin
      retire_s = 1'b0;
    end
    if (retire_s && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
    mem_err_d = mem_err_q | timeout_s;
  end

  // State and bookkeeping registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_RESET;
      wait_cnt_q <= 8'd0;
      retired_q  <= {CNT_W{1'b0}};
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign state_o     = state_q;
  assign is_halted_o = (state_q == S_HALT);
  assign mem_err_o   = mem_err_q;
  assign retired_o   = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm: a driver queues per-cycle expected outputs,
// an independent monitor pops and compares them on the falling edge.
module tb_mc_control_fsm;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2, ST_WB = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4, ST_MEM = 3'd6, ST_RST = 3'd7;

  // strobes: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write, wwd_out}
  localparam logic [7:0] SB_0   = 8'b0000_0000;
  localparam logic [7:0] SB_IFR = 8'b1001_0100;
  localparam logic [7:0] SB_IFW = 8'b0001_0000;
  localparam logic [7:0] SB_WB  = 8'b0000_0010;
  localparam logic [7:0] SB_LWM = 8'b0011_0000;
  localparam logic [7:0] SB_SWM = 8'b0010_1000;
  localparam logic [7:0] SB_BR  = 8'b0100_0000;
  localparam logic [7:0] SB_JAL = 8'b1000_0010;
  localparam logic [7:0] SB_WWD = 8'b0000_0001;

  // selects: {mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_source}
  localparam logic [9:0] SL_0   = 10'b00_00_00_00_00;
  localparam logic [9:0] SL_IF  = 10'b00_00_00_01_00;
  localparam logic [9:0] SL_ID  = 10'b00_00_00_10_00;
  localparam logic [9:0] SL_EXR = 10'b00_00_01_00_00;
  localparam logic [9:0] SL_EXI = 10'b00_00_01_10_00;
  localparam logic [9:0] SL_LHI = 10'b00_00_10_00_00;
  localparam logic [9:0] SL_BR  = 10'b00_00_01_00_10;
  localparam logic [9:0] SL_JAL = 10'b10_10_00_10_01;
  localparam logic [9:0] SL_WBR = 10'b00_01_00_00_00;
  localparam logic [9:0] SL_WBL = 10'b01_00_00_00_00;

  localparam logic [3:0] A_ADD = 4'd0, A_ORR = 4'd3, A_ARS = 4'd7, A_BEQ = 4'd9, A_ID = 4'd12;

  typedef struct packed {
    logic [2:0]  st;
    logic [7:0]  sb;
    logic [9:0]  sl;
    logic [3:0]  al;
    logic        hl;
    logic        er;
    logic [15:0] rt;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  opcode;
  logic [5:0]  funct;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0]  mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_source;
  logic [3:0]  alu_op;
  logic        wwd_out, is_halted, mem_err;
  logic [2:0]  state;
  logic [15:0] retired;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_push = 0;
  int   n_pop = 0;
  int   cyc_no = 0;
  logic finish_req = 1'b0;

  mc_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode_i(opcode), .funct_i(funct), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .i_or_d_o(i_or_d),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_write_o(reg_write), .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .pc_source_o(pc_source),
    .alu_op_o(alu_op), .wwd_out_o(wwd_out), .is_halted_o(is_halted), .mem_err_o(mem_err),
    .state_o(state), .retired_o(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc_no, got, want);
    end
  endtask

  // One clock of stimulus plus the outputs expected during that clock
  task automatic cyc(input logic rst, input logic [3:0] op, input logic [5:0] fn, input logic rdy,
                     input logic [2:0] st, input logic [7:0] sb, input logic [9:0] sl,
                     input logic [3:0] al, input logic hl, input logic er, input logic [15:0] rt);
    reset_n   = rst;
    opcode    = op;
    funct     = fn;
    mem_ready = rdy;
    exp_q.push_back({st, sb, sl, al, hl, er, rt});
    n_push++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each queued expectation against the live outputs
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_pop++;
        cyc_no++;
        chk("state", {13'd0, state}, {13'd0, e.st});
        chk("strobes", {8'd0, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                        reg_write, wwd_out}, {8'd0, e.sb});
        chk("selects", {6'd0, mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_source}, {6'd0, e.sl});
        chk("alu_op", {12'd0, alu_op}, {12'd0, e.al});
        chk("flags", {14'd0, is_halted, mem_err}, {14'd0, e.hl, e.er});
        chk("retired", retired, e.rt);
      end else if (finish_req) begin
        chk("vectors_seen", n_pop[15:0], n_push[15:0]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    reset_n = 1'b0; opcode = 4'd0; funct = 6'd0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 4'd0, 6'd0, 1'b1, ST_RST, SB_0, SL_0, A_ADD, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 4'd0, 6'd0, 1'b1, ST_RST, SB_0, SL_0, A_ADD, 1'b0, 1'b0, 16'd0);
    // ADD
    cyc(1'b1, 4'd15, 6'd0, 1'b1, ST_IF, SB_IFR, SL_IF,  A_ADD, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 4'd15, 6'd0, 1'b1, ST_ID, SB_0,   SL_ID,  A_ADD, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 4'd15, 6'd0, 1'b1, ST_EX, SB_0,   SL_EXR, A_ADD, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 4'd15, 6'd0, 1'b1, ST_WB, SB_WB,  SL_WBR, A_ADD, 1'b0, 1'b0, 16'd0);
    // LWD with three wait cycles in MEM
    cyc(1'b1, 4'd7, 6'd0, 1'b1, ST_IF, SB_IFR, SL_IF,  A_ADD, 1'b0, 1'b0, 16'd1);
    cyc(1'b1, 4'd7, 6'd0, 1'b1, ST_ID, SB_0,   SL_ID,  A_ADD, 1'b0, 1'b0, 16'd1);
    cyc(1'b1, 4'd7, 6'd0, 1'b1, ST_EX, SB_0,   SL_EXI, A_ADD, 1'b0, 1'b0, 16'd1);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 4'd7, 6'd0, 1'b0, ST_MEM, SB_LWM, SL_0, A_ADD, 1'b0, 1'b0, 16'd1);
    cyc(1'b1, 4'd7, 6'd0, 1'b1, ST_MEM, SB_LWM, SL_0,  A_ADD, 1'b0, 1'b0, 16'd1);
    cyc(1'b1, 4'd7, 6'd0, 1'b1, ST_WB,  SB_WB, SL_WBL, A_ADD, 1'b0, 1'b0, 16'd1);
    // BEQ
    cyc(1'b1, 4'd1, 6'd0, 1'b1, ST_IF, SB_IFR, SL_IF, A_ADD, 1'b0, 1'b0, 16'd2);
    cyc(1'b1, 4'd1, 6'd0, 1'b1, ST_ID, SB_0,   SL_ID, A_ADD, 1'b0, 1'b0, 16'd2);
    cyc(1'b1, 4'd1, 6'd0, 1'b1, ST_EX, SB_BR,  SL_BR, A_BEQ, 1'b0, 1'b0, 16'd2);
    // JAL
    cyc(1'b1, 4'd10, 6'd0, 1'b1, ST_IF, SB_IFR, SL_IF,  A_ADD, 1'b0, 1'b0, 16'd3);
    cyc(1'b1, 4'd10, 6'd0, 1'b1, ST_ID, SB_JAL, SL_JAL, A_ADD, 1'b0, 1'b0, 16'd3);
    // ORI
    cyc(1'b1, 4'd5, 6'd0, 1'b1, ST_IF, SB_IFR, SL_IF,  A_ADD, 1'b0, 1'b0, 16'd4);
    cyc(1'b1, 4'd5, 6'd0, 1'b1, ST_ID, SB_0,   SL_ID,  A_ADD, 1'b0, 1'b0, 16'd4);
    cyc(1'b1, 4'd5, 6'd0, 1'b1, ST_EX, SB_0,   SL_EXI, A_ORR, 1'b0, 1'b0, 16'd4);
    cyc(1'b1, 4'd5, 6'd0, 1'b1, ST_WB, SB_WB,  SL_0,   A_ADD, 1'b0, 1'b0, 16'd4);
    // WWD
    cyc(1'b1, 4'd15, 6'd28, 1'b1, ST_IF, SB_IFR, SL_IF, A_ADD, 1'b0, 1'b0, 16'd5);
    cyc(1'b1, 4'd15, 6'd28, 1'b1, ST_ID, SB_WWD, SL_ID, A_ADD, 1'b0, 1'b0, 16'd5);
    // LHI
    cyc(1'b1, 4'd6, 6'd0, 1'b1, ST_IF, SB_IFR, SL_IF,  A_ADD, 1'b0, 1'b0, 16'd6);
    cyc(1'b1, 4'd6, 6'd0, 1'b1, ST_ID, SB_0,   SL_ID,  A_ADD, 1'b0, 1'b0, 16'd6);
    cyc(1'b1, 4'd6, 6'd0, 1'b1, ST_EX, SB_0,   SL_LHI, A_ID,  1'b0, 1'b0, 16'd6);
    cyc(1'b1, 4'd6, 6'd0, 1'b1, ST_WB, SB_WB,  SL_0,   A_ADD, 1'b0, 1'b0, 16'd6);
    // SHR
    cyc(1'b1, 4'd15, 6'd7, 1'b1, ST_IF, SB_IFR, SL_IF,  A_ADD, 1'b0, 1'b0, 16'd7);
    cyc(1'b1, 4'd15, 6'd7, 1'b1, ST_ID, SB_0,   SL_ID,  A_ADD, 1'b0, 1'b0, 16'd7);
    cyc(1'b1, 4'd15, 6'd7, 1'b1, ST_EX, SB_0,   SL_EXR, A_ARS, 1'b0, 1'b0, 16'd7);
    cyc(1'b1, 4'd15, 6'd7, 1'b1, ST_WB, SB_WB,  SL_WBR, A_ADD, 1'b0, 1'b0, 16'd7);
    // undefined opcode retires as a no-op from ID
    cyc(1'b1, 4'd12, 6'd0, 1'b1, ST_IF, SB_IFR, SL_IF, A_ADD, 1'b0, 1'b0, 16'd8);
    cyc(1'b1, 4'd12, 6'd0, 1'b1, ST_ID, SB_0,   SL_ID, A_ADD, 1'b0, 1'b0, 16'd8);
    // SWD, immediate ready
    cyc(1'b1, 4'd8, 6'd0, 1'b1, ST_IF,  SB_IFR, SL_IF,  A_ADD, 1'b0, 1'b0, 16'd9);
    cyc(1'b1, 4'd8, 6'd0, 1'b1, ST_ID,  SB_0,   SL_ID,  A_ADD, 1'b0, 1'b0, 16'd9);
    cyc(1'b1, 4'd8, 6'd0, 1'b1, ST_EX,  SB_0,   SL_EXI, A_ADD, 1'b0, 1'b0, 16'd9);
    cyc(1'b1, 4'd8, 6'd0, 1'b1, ST_MEM, SB_SWM, SL_0,   A_ADD, 1'b0, 1'b0, 16'd9);
    // SWD aborted by reset while waiting in MEM
    cyc(1'b1, 4'd8, 6'd0, 1'b1, ST_IF,  SB_IFR, SL_IF,  A_ADD, 1'b0, 1'b0, 16'd10);
    cyc(1'b1, 4'd8, 6'd0, 1'b1, ST_ID,  SB_0,   SL_ID,  A_ADD, 1'b0, 1'b0, 16'd10);
    cyc(1'b1, 4'd8, 6'd0, 1'b1, ST_EX,  SB_0,   SL_EXI, A_ADD, 1'b0, 1'b0, 16'd10);
    cyc(1'b1, 4'd8, 6'd0, 1'b0, ST_MEM, SB_SWM, SL_0,   A_ADD, 1'b0, 1'b0, 16'd10);
    cyc(1'b0, 4'd8, 6'd0, 1'b0, ST_MEM, SB_SWM, SL_0,   A_ADD, 1'b0, 1'b0, 16'd10);
    cyc(1'b1, 4'd8, 6'd0, 1'b0, ST_RST, SB_0,   SL_0,   A_ADD, 1'b0, 1'b0, 16'd0);
    // HLT then 20 cycles of arbitrary inputs, then reset
    cyc(1'b1, 4'd15, 6'd29, 1'b1, ST_IF, SB_IFR, SL_IF, A_ADD, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 4'd15, 6'd29, 1'b1, ST_ID, SB_0,   SL_ID, A_ADD, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 4'($urandom), 6'($urandom), 1'($urandom), ST_HALT, SB_0, SL_0, A_ADD, 1'b1, 1'b0, 16'd1);
    cyc(1'b0, 4'd0, 6'd0, 1'b1, ST_HALT, SB_0, SL_0, A_ADD, 1'b1, 1'b0, 16'd1);
    cyc(1'b1, 4'd0, 6'd0, 1'b0, ST_RST,  SB_0, SL_0, A_ADD, 1'b0, 1'b0, 16'd0);
    // fetch timeout: WAIT_MAX+1 = 16 cycles without mem_ready
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 4'd15, 6'd0, 1'b0, ST_IF, SB_IFW, SL_IF, A_ADD, 1'b0, 1'b0, 16'd0);
    cyc(1'b1, 4'd15, 6'd0, 1'b0, ST_HALT, SB_0, SL_0, A_ADD, 1'b1, 1'b1, 16'd0);
    cyc(1'b1, 4'd15, 6'd0, 1'b1, ST_HALT, SB_0, SL_0, A_ADD, 1'b1, 1'b1, 16'd0);
    cyc(1'b0, 4'd15, 6'd0, 1'b1, ST_HALT, SB_0, SL_0, A_ADD, 1'b1, 1'b1, 16'd0);
    cyc(1'b1, 4'd15, 6'd0, 1'b1, ST_RST,  SB_0, SL_0, A_ADD, 1'b0, 1'b0, 16'd0);
    finish_req = 1'b1;
  end

endmodule
